// File: rtl/alu_sequencer.sv
// Issuing side of the 8-bit ALU interface: accepts one instruction at a time,
// reads operands from an internal register file, drives the ALU from
// registers, captures its result and writes it back.
module alu_sequencer #(
   parameter int unsigned NREGS  = 8,
   parameter logic [5:0]  LDI_OP = 6'b111111,
   parameter logic [5:0]  CMP_OP = 6'b001000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [5:0] instr_op,
   input  logic [2:0] instr_rd,
   input  logic [2:0] instr_rs1,
   input  logic [2:0] instr_rs2,
   input  logic [7:0] instr_imm,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [5:0] alu_op,
   input  logic [7:0] alu_result,
   output logic       wb_valid,
   output logic [2:0] wb_rd,
   output logic [7:0] wb_data,
   output logic [1:0] flags,
   output logic       busy,
   input  logic [2:0] dbg_sel,
   output logic [7:0] dbg_data
);

   localparam int unsigned DW  = 8;
   localparam int unsigned OPW = 6;
   localparam int unsigned IW  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

   state_t state, state_next;

   logic [DW-1:0]  regs [NREGS];
   logic [OPW-1:0] op_q;
   logic [IW-1:0]  rd_q;
   logic [IW-1:0]  rs1_q;
   logic [IW-1:0]  rs2_q;
   logic [DW-1:0]  imm_q;
   logic [DW-1:0]  result_q;
   logic [DW-1:0]  result_c;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state decode: fixed four-step walk once an instruction is taken
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (instr_valid) state_next = READ;
         READ:    state_next = EXEC;
         EXEC:    state_next = WB;
         WB:      state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Load-immediate bypasses the ALU
   assign result_c = (op_q == LDI_OP) ? imm_q : alu_result;

   // Debug read port into the register file
   assign dbg_data = regs[dbg_sel];

   // Datapath, register file and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         op_q        <= '0;
         rd_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         imm_q       <= '0;
         result_q    <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
         wb_valid    <= 1'b0;
         wb_rd       <= '0;
         wb_data     <= '0;
         flags       <= 2'b00;
         instr_ready <= 1'b1;
         busy        <= 1'b0;
      end else begin
         instr_ready <= (state_next == IDLE);
         busy        <= (state_next != IDLE);
         wb_valid    <= (state_next == WB);
         case (state)
            IDLE: begin
               if (instr_valid) begin
                  op_q  <= instr_op;
                  rd_q  <= instr_rd;
                  rs1_q <= instr_rs1;
                  rs2_q <= instr_rs2;
                  imm_q <= instr_imm;
               end
            end
            READ: begin
               alu_a  <= regs[rs1_q];
               alu_b  <= regs[rs2_q];
               alu_op <= op_q;
            end
            EXEC: begin
               result_q <= result_c;
               wb_rd    <= rd_q;
               wb_data  <= result_c;
            end
            WB: begin
               regs[rd_q] <= result_q;
               if (op_q == CMP_OP) flags <= result_q[1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a small ALU model.
module tb_alu_sequencer;

   localparam logic [5:0] OP_ADD = 6'b000000;
   localparam logic [5:0] OP_SUB = 6'b000001;
   localparam logic [5:0] OP_AND = 6'b000010;
   localparam logic [5:0] OP_CMP = 6'b001000;
   localparam logic [5:0] OP_LDI = 6'b111111;
   localparam logic [5:0] OP_UND = 6'b010101;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [5:0] instr_op;
   logic [2:0] instr_rd, instr_rs1, instr_rs2;
   logic [7:0] instr_imm;
   logic [7:0] alu_a, alu_b;
   logic [5:0] alu_op;
   logic [7:0] alu_result;
   logic       wb_valid;
   logic [2:0] wb_rd;
   logic [7:0] wb_data;
   logic [1:0] flags;
   logic       busy;
   logic [2:0] dbg_sel;
   logic [7:0] dbg_data;

   int n_cmp = 0;
   int n_err = 0;

   alu_sequencer dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd),
      .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_imm(instr_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .flags(flags), .busy(busy), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // ALU model: compare returns {a>b, a==b}; undefined opcodes return 0
   always_comb begin
      alu_result = 8'h00;
      case (alu_op)
         OP_ADD:  alu_result = alu_a + alu_b;
         OP_SUB:  alu_result = alu_a - alu_b;
         OP_AND:  alu_result = alu_a & alu_b;
         OP_CMP:  alu_result = {6'b0, alu_a > alu_b, alu_a == alu_b};
         default: alu_result = 8'h00;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic read_reg(input logic [2:0] idx, input logic [7:0] exp, input string tag);
      dbg_sel = idx;
      #1;
      check(tag, 32'(dbg_data), 32'(exp));
   endtask

   // Present one instruction and return #1 after its accept edge
   task automatic issue(input logic [5:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2, input logic [7:0] imm);
      int n = 0;
      while (!instr_ready && n < 10) begin
         step();
         n++;
      end
      if (!instr_ready) check("ready_timeout", 32'(instr_ready), 32'd1);
      instr_valid = 1'b1;
      instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
      step();
      instr_valid = 1'b0;
      instr_op = 6'h2A; instr_rd = 3'd0; instr_rs1 = 3'd7; instr_rs2 = 3'd7; instr_imm = 8'h55;
   endtask

   // Full instruction with per-stage checks; ends #1 after the WB edge
   task automatic run(input string tag, input logic [5:0] op, input logic [2:0] rd,
                      input logic [2:0] rs1, input logic [2:0] rs2, input logic [7:0] imm,
                      input logic chk_alu, input logic [7:0] exp_a, input logic [7:0] exp_b,
                      input logic [7:0] exp_wb);
      issue(op, rd, rs1, rs2, imm);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      step();
      if (chk_alu) begin
         check({tag, "_alu_a"}, 32'(alu_a), 32'(exp_a));
         check({tag, "_alu_b"}, 32'(alu_b), 32'(exp_b));
         check({tag, "_alu_op"}, 32'(alu_op), 32'(op));
      end
      step();
      check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
      check({tag, "_wb_rd"}, 32'(wb_rd), 32'(rd));
      check({tag, "_wb_data"}, 32'(wb_data), 32'(exp_wb));
      step();
      check({tag, "_wb_drop"}, 32'(wb_valid), 32'd0);
      check({tag, "_ready"}, 32'(instr_ready), 32'd1);
      read_reg(rd, exp_wb, {tag, "_dbg"});
   endtask

   int accept_cyc [3];
   int n_acc;
   int n_wb;

   initial begin
      rst = 1'b1;
      instr_valid = 1'b0;
      instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0;
      dbg_sel = '0;
      step();
      step();
      rst = 1'b0;
      check("rst_ready", 32'(instr_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      read_reg(3'd5, 8'h00, "rst_r5");

      // Loads, arithmetic and a same-register hazard
      run("ldi_r1", OP_LDI, 3'd1, 3'd0, 3'd0, 8'h0F, 1'b0, 8'h00, 8'h00, 8'h0F);
      run("ldi_r2", OP_LDI, 3'd2, 3'd0, 3'd0, 8'h03, 1'b0, 8'h00, 8'h00, 8'h03);
      read_reg(3'd1, 8'h0F, "dbg_r1_0f");
      run("add_r3", OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 8'h0F, 8'h03, 8'h12);
      run("sub_r4", OP_SUB, 3'd4, 3'd1, 3'd2, 8'h00, 1'b1, 8'h0F, 8'h03, 8'h0C);
      run("and_r5", OP_AND, 3'd5, 3'd1, 3'd2, 8'h00, 1'b1, 8'h0F, 8'h03, 8'h03);
      run("add_r1", OP_ADD, 3'd1, 3'd1, 3'd1, 8'h00, 1'b1, 8'h0F, 8'h0F, 8'h1E);
      read_reg(3'd1, 8'h1E, "dbg_r1_1e");
      check("flags_before_cmp", 32'(flags), 32'd0);

      // Compare latches flags at the WB edge; later ops leave them alone
      run("cmp_r7", OP_CMP, 3'd7, 3'd1, 3'd2, 8'h00, 1'b1, 8'h1E, 8'h03, 8'h02);
      check("cmp_flags", 32'(flags), 32'd2);
      run("add_r6", OP_ADD, 3'd6, 3'd2, 3'd2, 8'h00, 1'b1, 8'h03, 8'h03, 8'h06);
      check("add_keeps_flags", 32'(flags), 32'd2);
      run("ldi_r0", OP_LDI, 3'd0, 3'd0, 3'd0, 8'hC3, 1'b0, 8'h00, 8'h00, 8'hC3);
      check("ldi_keeps_flags", 32'(flags), 32'd2);
      run("und_r0", OP_UND, 3'd0, 3'd1, 3'd2, 8'h77, 1'b1, 8'h1E, 8'h03, 8'h00);

      // Back-to-back: instr_valid held high across three instructions
      n_acc = 0;
      n_wb  = 0;
      instr_valid = 1'b1;
      instr_op = OP_ADD; instr_rd = 3'd3; instr_rs1 = 3'd2; instr_rs2 = 3'd2; instr_imm = 8'h00;
      for (int c = 0; c < 16; c++) begin
         logic acc;
         acc = instr_valid & instr_ready;
         if (acc && n_acc < 3) accept_cyc[n_acc] = c;
         step();
         if (wb_valid) n_wb++;
         if (acc) begin
            n_acc++;
            case (n_acc)
               1: begin instr_op = OP_SUB; instr_rd = 3'd4; instr_rs1 = 3'd1; instr_rs2 = 3'd2; end
               2: begin instr_op = OP_LDI; instr_rd = 3'd5; instr_imm = 8'hA5; end
               default: instr_valid = 1'b0;
            endcase
         end
      end
      check("b2b_accepts", 32'(n_acc), 32'd3);
      check("b2b_accept0", 32'(accept_cyc[0]), 32'd0);
      check("b2b_accept1", 32'(accept_cyc[1]), 32'd4);
      check("b2b_accept2", 32'(accept_cyc[2]), 32'd8);
      check("b2b_wb_pulses", 32'(n_wb), 32'd3);
      read_reg(3'd3, 8'h06, "b2b_r3");
      read_reg(3'd4, 8'h1B, "b2b_r4");
      read_reg(3'd5, 8'hA5, "b2b_r5");

      // Reset while the ADD r6 is in EXEC
      issue(OP_ADD, 3'd6, 3'd1, 3'd2, 8'h00);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
      check("mid_rst_ready", 32'(instr_ready), 32'd1);
      check("mid_rst_flags", 32'(flags), 32'd0);
      step();
      check("mid_rst_no_wb", 32'(wb_valid), 32'd0);
      check("mid_rst_idle", 32'(busy), 32'd0);
      read_reg(3'd6, 8'h00, "mid_rst_r6");
      read_reg(3'd1, 8'h00, "mid_rst_r1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issuing side of the 8-bit ALU interface.
- Accepts one register-to-register instruction at a time over a valid/ready handshake and reads two operands from an internal 8x8 register file.
- Drives the ALU's a/b/op inputs from registers, captures the ALU's combinational result, and writes it back to the destination register.
- Also supports load-immediate and latches compare results into a flags register.

Parameters:
- NREGS, 8: number of register-file entries; index width fixed at 3 bits.
- LDI_OP, 6'b111111: opcode treated as load-immediate; bypasses the ALU.
- CMP_OP, 6'b001000: opcode whose result[1:0] is latched into flags.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- instr_valid  input  1  instruction present on the instr_* inputs.
- instr_ready  output  1  sequencer can accept an instruction; high only in IDLE.
- instr_op  input  6  opcode, using the ALU op encoding or LDI_OP.
- instr_rd  input  3  destination register index.
- instr_rs1  input  3  source A register index.
- instr_rs2  input  3  source B register index.
- instr_imm  input  8  immediate; used only by LDI_OP.
- alu_a  output  8  registered operand A to the ALU.
- alu_b  output  8  registered operand B to the ALU.
- alu_op  output  6  registered opcode to the ALU.
- alu_result  input  8  combinational result from the ALU.
- wb_valid  output  1  one-cycle pulse: write-back performed this cycle.
- wb_rd  output  3  register written; valid while wb_valid is high.
- wb_data  output  8  value written; valid while wb_valid is high.
- flags  output  2  last compare result.
- busy  output  1  high whenever the state is not IDLE.
- dbg_sel  input  3  debug register-file read index.
- dbg_data  output  8  combinational read of regfile[dbg_sel].

Behaviour:
- Reset is synchronous and active-high. At a clk edge with rst=1:
  - state = IDLE
  - all register-file entries = 0x00
  - alu_a, alu_b, alu_op = 0
  - wb_valid = 0, wb_rd = 0, wb_data = 0
  - flags = 2'b00
  - rst overrides every other input in that cycle.
- States:
  - IDLE: instr_ready = 1. A transfer occurs when instr_valid and instr_ready are both high at an edge. The instruction fields are latched and the FSM goes to READ. With no transfer it stays in IDLE.
  - READ: alu_a <= regfile[rs1], alu_b <= regfile[rs2], alu_op <= op. Next state is EXEC.
  - EXEC: ALU output settles combinationally. result_q <= (op == LDI_OP) ? imm : alu_result. Next state is WB.
  - WB: regfile[rd] <= result_q; wb_valid = 1 for exactly this cycle, with wb_rd = rd and wb_data = result_q. If op == CMP_OP, flags <= result_q[1:0] at the same edge. Next state is IDLE.
- Latency:
  - Instruction accepted at edge T; write-back visible at edge T+3; instr_ready high again in the cycle after the WB edge.
  - Maximum throughput is one instruction per 4 cycles.
- Handshake:
  - instr_* fields are sampled only at the accept edge. Changes to them while busy are ignored.
  - instr_valid may stay high continuously; each IDLE cycle with instr_valid high accepts the next instruction.
- Hazards:
  - Operands are read in READ, after any earlier write-back has completed. No forwarding is needed.
  - rd == rs1 == rs2 is legal: the old value is read and the new value is written.
- Opcodes:
  - Undefined opcodes are passed through to the ALU unchanged; whatever the ALU returns (0x00) is written.
  - The sequencer does not interpret flags bits beyond latching them.
  - Non-compare ops, including LDI, leave flags unchanged.
- Widths: all data is 8-bit; no carry or overflow is captured.
- dbg_data is a purely combinational read. A write-back becomes visible on dbg_data in the cycle after the WB edge.
- Reset mid-operation (READ, EXEC or WB): the in-flight instruction is dropped, no write-back occurs, and the register file is cleared.

Test Plan:
- Reset then LDI r1,0x0F; LDI r2,0x03 -> wb_valid pulses with wb_rd=1/wb_data=0x0F, then wb_rd=2/wb_data=0x03; dbg_sel=1 reads 0x0F.
- ADD (op 000000) r3 = r1 + r2 after the loads above, accepted at edge T -> wb_valid at T+3 with wb_rd=3, wb_data=0x12; alu_a=0x0F, alu_b=0x03 during EXEC.
- SUB r4 = r1 - r2 -> wb_data=0x0C. AND r5 = r1 & r2 -> 0x03. ADD r1 = r1 + r1 -> 0x1E, and a later dbg read of r1 returns 0x1E.
- CMP (op 001000) with the bench ALU model returning 0x02 -> flags=2'b10 after the WB edge; a following ADD leaves flags at 2'b10.
- instr_valid held high with 3 queued instructions -> instr_ready pulses every 4th cycle; accepts at T, T+4, T+8; exactly 3 wb_valid pulses.
- Assert rst in EXEC of ADD r6 -> no wb_valid, r6=0x00, flags=2'b00, instr_ready=1 in the cycle after rst deasserts.
